// File: rtl/arb_mux2a1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux2a1_pkg
// Purpose  : Shared types and constants for the arb_mux2a1 arbiter/sequencer:
//            FSM state encoding, burst counter width and the IDLE-state
//            round-robin pick.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package arb_mux2a1_pkg;

  // Burst counter width; supports MAX_BURST values 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  // Source to grant from IDLE. This is only meaningful when at least one
  // request is high. When both sources request, the one that was not served
  // last wins.
  function automatic logic pick_idle(input logic req0, input logic req1,
                                     input logic last_served);
    if (req0 && req1) begin
      return !last_served;
    end
    return req1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux2a1_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux2a1_if
// Purpose  : Bundles the two producer handshakes, the registered output
//            handshake and the status outputs of arb_mux2a1.
// Ports    : slave  - arbiter view (reqs/data/y_ready in; acks/y/status out)
//            master - environment view (reverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface arb_mux2a1_if #(
  parameter int W = 8
);
  logic         req0;
  logic [W-1:0] d0;
  logic         ack0;
  logic         req1;
  logic [W-1:0] d1;
  logic         ack1;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic         sel;
  logic         busy;

  modport slave (
    input  req0, d0, req1, d1, y_ready,
    output ack0, ack1, y, y_valid, sel, busy
  );

  modport master (
    output req0, d0, req1, d1, y_ready,
    input  ack0, ack1, y, y_valid, sel, busy
  );
endinterface
`default_nettype wire

// File: rtl/arb_mux2a1_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux2a1_mux
// Purpose  : W-bit wide 2:1 multiplexer built from one 2:1 cell per bit.
// Ports    : sel_i - 0 selects d0_i, 1 selects d1_i
//            d0_i  - source 0 word
//            d1_i  - source 1 word
//            y_o   - selected word
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux2a1_mux #(
  parameter int W = 8
) (
  input  logic         sel_i,
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  output logic [W-1:0] y_o
);

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      assign y_o[i] = sel_i ? d1_i[i] : d0_i[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/arb_mux2a1.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux2a1
// Purpose  : Two-requester round-robin arbiter and sequencer for a shared
//            2:1 mux datapath. It grants one source at a time, drives the mux
//            select, and moves the selected word into a registered output
//            stage with a valid/ready handshake. A grant yields to a waiting
//            requester after MAX_BURST accepted transfers.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - arb_mux2a1_if.slave: req0/d0/ack0, req1/d1/ack1,
//                    y/y_valid/y_ready, sel, busy
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux2a1
  import arb_mux2a1_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  arb_mux2a1_if.slave  bus
);

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [W-1:0]       y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;

  logic               free_w;
  logic               ack0_w, ack1_w;
  logic               xfer_w;
  logic               hit_max_w;
  logic [CNT_W-1:0]   cnt_inc_w;
  logic [W-1:0]       mux_w;

  // The output register can accept a word if it is empty, or if it is being
  // drained in this same cycle. This gives back-to-back throughput.
  assign free_w    = !y_valid_q || bus.y_ready;
  assign ack0_w    = (state_q == ST_GRANT0) && bus.req0 && free_w;
  assign ack1_w    = (state_q == ST_GRANT1) && bus.req1 && free_w;
  assign xfer_w    = ack0_w || ack1_w;
  assign cnt_inc_w = cnt_q + 1'b1;
  assign hit_max_w = xfer_w && (cnt_inc_w == CNT_W'(MAX_BURST));

  // sel_q already reflects the granted source in the grant's first cycle,
  // because it is registered from the next state. The mux can therefore be
  // driven straight from the register with no switch bubble.
  arb_mux2a1_mux #(
    .W (W)
  ) u_mux (
    .sel_i (sel_q),
    .d0_i  (bus.d0),
    .d1_i  (bus.d1),
    .y_o   (mux_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    if (xfer_w) begin
      y_d       = mux_w;
      y_valid_d = 1'b1;
      last_d    = ack1_w;
      cnt_d     = cnt_inc_w;
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = pick_idle(bus.req0, bus.req1, last_q) ? ST_GRANT1 : ST_GRANT0;
        end
        cnt_d = '0;
      end
      ST_GRANT0: begin
        // A burst hit implies req0 was high. Yielding on a burst limit and
        // yielding on withdrawal are therefore mutually exclusive.
        if (bus.req1 && (hit_max_w || !bus.req0)) begin
          state_d = ST_GRANT1;
          cnt_d   = '0;
        end else if (!bus.req0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (hit_max_w) begin
          cnt_d   = '0;
        end
      end
      ST_GRANT1: begin
        if (bus.req0 && (hit_max_w || !bus.req1)) begin
          state_d = ST_GRANT0;
          cnt_d   = '0;
        end else if (!bus.req1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (hit_max_w) begin
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    sel_d = (state_d == ST_GRANT1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.ack0    = ack0_w;
  assign bus.ack1    = ack1_w;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire
